fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the 5-stage pipelined CPU. Replaces the single-cycle PC-to-instruction-memory path.
- Issues sequential fetch addresses to an in-order, variable-latency instruction memory and buffers up to DEPTH instructions, tagged with their PC, for decode.
- Handles branch redirects by flushing buffered entries and silently dropping responses still in flight.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_queue_if.sv | 31 +++
 rtl/ring_ptr.sv | 26 ++
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction-fetch front end.
// Ports: none (package only).
// Slot record carries the PC, the returned instruction and a filled flag.
package fetch_pkg;

  localparam int ADDR_W      = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } fetch_slot_t;

  // Ring pointer width; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: imem request/response, redirect, and decode hand-off.
// master = fetch_queue side; slave = imem + pipeline side.
// Ports: imem_req/imem_addr out, imem_rsp_* in, redirect/redirect_pc in, out_* valid/ready.
interface fetch_queue_if #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  out_pc_plus4;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
    input  imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
    output imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
  );

endinterface

// File: rtl/ring_ptr.sv
// Registered ring pointer counting 0..DEPTH-1 and wrapping back to 0.
// Ports: clk, reset (sync, active-high), inc (advance), clr (force 0), ptr.
// clr takes priority over inc; latency one cycle from inc/clr to ptr.
module ring_ptr
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ptr <= '0;
    end else if (inc) begin
      // Explicit wrap so non-power-of-two depths work.
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues sequential PCs to an in-order imem and buffers PC-tagged instructions.
// Latency: request at t, 1-cycle imem response at t+1, out_valid at t+2; sustains 1 instr/cycle.
// Backpressure: out_ready low holds the head; issue stops once buffered + in-flight + discards reach DEPTH.
// Ports: clk, reset (sync, active-high), bus (fetch_queue_if.master: imem_*, redirect*, out_*).
module fetch_queue #(
  parameter int                ADDR_W   = fetch_pkg::ADDR_W,
  parameter int                INSTR_W  = fetch_pkg::INSTR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  import fetch_pkg::*;

  localparam int                PTR_W   = ptr_width(DEPTH);
  localparam int                CNT_W   = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN   = ~ADDR_W'(INSTR_BYTES - 1);

  fetch_slot_t slots [DEPTH];

  logic [ADDR_W-1:0]  fetch_pc;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   fill;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   alloc;
  logic [CNT_W-1:0]   discard;
  logic [CNT_W-1:0]   unfilled;
  logic [CNT_W:0]     occupancy;
  logic               issue;
  logic               rsp_keep;
  logic               deq;
  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0]  head_pc;

  // Issue looks only at registered counts, so a same-cycle dequeue never frees a slot early.
  assign occupancy = {1'b0, alloc} + {1'b0, discard};
  assign issue     = !reset && !bus.redirect && (occupancy < {1'b0, DEPTH_C});
  assign rsp_keep  = bus.imem_rsp_valid && (discard == '0);

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;

  assign head_instr = slots[head].instr;
  assign head_pc    = slots[head].pc;

  assign bus.out_valid    = !reset && slots[head].filled;
  assign bus.out_instr    = bus.out_valid ? head_instr : '0;
  assign bus.out_pc       = bus.out_valid ? head_pc : '0;
  assign bus.out_pc_plus4 = bus.out_valid ? head_pc + STEP : '0;

  assign deq = bus.out_valid && bus.out_ready;

  // Allocated-but-unfilled slots lie between fill and tail. When fill == tail the
  // ring is either fully unfilled (all DEPTH allocated, slot at fill still empty)
  // or holds no outstanding request.
  always_comb begin
    unfilled = '0;
    if (tail > fill) begin
      unfilled = CNT_W'(tail) - CNT_W'(fill);
    end else if (tail < fill) begin
      unfilled = DEPTH_C - CNT_W'(fill) + CNT_W'(tail);
    end else if ((alloc == DEPTH_C) && !slots[fill].filled) begin
      unfilled = DEPTH_C;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      alloc    <= '0;
      discard  <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & ALIGN;
      alloc    <= '0;
      // Every unfilled request becomes a future drop; a response landing this
      // cycle already retires one of them (old discard or the flushed fill slot).
      discard  <= discard + unfilled - CNT_W'(bus.imem_rsp_valid);
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + STEP;
      end
      alloc <= alloc + CNT_W'(issue) - CNT_W'(deq);
      if (bus.imem_rsp_valid && (discard != '0)) begin
        discard <= discard - CNT_W'(1);
      end
    end
  end

  // issue/fill/dequeue never target the same slot in one cycle: issue needs a free
  // slot at tail, a kept response targets an allocated unfilled slot, and dequeue
  // needs a filled head.
  always_ff @(posedge clk) begin
    if (reset || bus.redirect) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i].filled <= 1'b0;
      end
    end else begin
      if (issue) begin
        slots[tail].pc     <= fetch_pc;
        slots[tail].filled <= 1'b0;
      end
      if (rsp_keep) begin
        slots[fill].instr  <= bus.imem_rsp_data;
        slots[fill].filled <= 1'b1;
      end
      if (deq) begin
        slots[head].filled <= 1'b0;
      end
    end
  end

  ring_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .inc   (deq),
    .clr   (bus.redirect),
    .ptr   (head)
  );

  ring_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fill (
    .clk   (clk),
    .reset (reset),
    .inc   (rsp_keep),
    .clr   (bus.redirect),
    .ptr   (fill)
  );

  ring_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail (
    .clk   (clk),
    .reset (reset),
    .inc   (issue),
    .clr   (bus.redirect),
    .ptr   (tail)
  );

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int AW    = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_queue #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .DEPTH    (DEPTH),
    .RESET_PC (64'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { logic [AW-1:0] pc; logic [IW-1:0] instr; } exp_t;
  typedef struct { logic [AW-1:0] addr; int cyc; } req_t;
  typedef struct { logic [IW-1:0] data; int due; } pend_t;

  exp_t  exp_q[$];
  req_t  req_log[$];
  pend_t pend_q[$];
  int    hs_cyc[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  int hs_count = 0;
  int t0 = 0;
  int rel = 0;

  // Memory image: each word is a fixed pattern XOR the low address bits.
  function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // In-order imem with configurable latency; reset together with the DUT.
  always @(negedge clk) begin
    if (reset) begin
      pend_q.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = pend_q[0].data;
        void'(pend_q.pop_front());
      end
      if (bus.imem_req) begin
        pend_q.push_back('{word_at(bus.imem_addr), cyc + lat});
        req_log.push_back('{bus.imem_addr, cyc});
      end
    end
  end

  // Output monitor: pops the scoreboard on every decode handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        hs_count++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %h instr %h, expected nothing", bus.out_pc, bus.out_instr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_pc", bus.out_pc, e.pc);
          check("out_instr", {32'h0, bus.out_instr}, {32'h0, e.instr});
          check("out_pc_plus4", bus.out_pc_plus4, e.pc + 64'd4);
        end
      end else if (!bus.out_valid) begin
        check("idle_outputs_zero", {bus.out_instr, 32'h0} | bus.out_pc | bus.out_pc_plus4, 64'h0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] pc);
    exp_q.push_back('{pc, word_at(pc)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.out_ready = 1'b0;
    tick(2);
    req_log.delete();
    hs_cyc.delete();
    hs_count = 0;
    reset = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (hs_count < target && n < budget) begin
      tick(1);
      n++;
    end
    bus.out_ready = 1'b0;
    if (hs_count < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d handshakes, expected %0d", name, hs_count, target);
    end
  endtask

  task automatic end_test(input string name);
    check({name, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;
    reset           = 1'b1;

    // Reset state.
    tick(3);
    check("rst_imem_req", 64'(bus.imem_req), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_instr", {32'h0, bus.out_instr}, 64'd0);
    check("rst_out_pc", bus.out_pc, 64'd0);
    check("rst_out_pc_plus4", bus.out_pc_plus4, 64'd0);

    // Streaming with 1-cycle imem.
    lat = 1;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(64'(4 * i));
    wait_hs(8, 40, "stream");
    check("stream_first_addr", req_log[0].addr, 64'h0);
    check("stream_first_req_cyc", 64'(req_log[0].cyc - t0), 64'd0);
    check("stream_third_addr", req_log[2].addr, 64'h8);
    if (hs_cyc.size() >= 8) begin
      check("stream_first_out_cyc", 64'(hs_cyc[0] - t0), 64'd2);
      check("stream_last_out_cyc", 64'(hs_cyc[7] - t0), 64'd9);
    end
    end_test("stream");

    // Fill to DEPTH with decode stalled, then drain.
    lat = 1;
    do_reset();
    tick(8);
    check("full_req_count", 64'(req_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      check("full_addr", req_log[i].addr, 64'(4 * i));
    check("full_imem_req", 64'(bus.imem_req), 64'd0);
    check("full_out_valid", 64'(bus.out_valid), 64'd1);
    check("full_head_pc", bus.out_pc, 64'h0);
    for (int i = 0; i < 8; i++) push_exp(64'(4 * i));
    rel = cyc;
    bus.out_ready = 1'b1;
    wait_hs(8, 40, "drain");
    if (req_log.size() >= 5) begin
      check("resume_addr", req_log[4].addr, 64'h10);
      check("resume_cyc", 64'(req_log[4].cyc - rel), 64'd1);
    end
    if (hs_cyc.size() >= 1) check("drain_first_cyc", 64'(hs_cyc[0] - rel), 64'd0);
    end_test("drain");

    // Redirect with two requests in flight on a 3-cycle imem.
    lat = 3;
    do_reset();
    bus.out_ready = 1'b1;
    tick(2);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h100;
    #1;
    check("redir_blocks_issue", 64'(bus.imem_req), 64'd0);
    tick(1);
    bus.redirect = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(64'h100 + 64'(4 * i));
    wait_hs(4, 60, "redir3");
    if (req_log.size() >= 3) begin
      check("redir3_new_addr", req_log[2].addr, 64'h100);
      check("redir3_new_cyc", 64'(req_log[2].cyc - t0), 64'd3);
    end
    if (hs_cyc.size() >= 1) check("redir3_first_out_cyc", 64'(hs_cyc[0] - t0), 64'd7);
    end_test("redir3");

    // Redirect coinciding with a response, one more outstanding (2-cycle imem).
    lat = 2;
    do_reset();
    bus.out_ready = 1'b1;
    tick(2);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h200;
    tick(1);
    bus.redirect = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(64'h200 + 64'(4 * i));
    wait_hs(4, 60, "redir_rsp");
    if (req_log.size() >= 3) check("redir_rsp_new_addr", req_log[2].addr, 64'h200);
    if (hs_cyc.size() >= 1) check("redir_rsp_first_out_cyc", 64'(hs_cyc[0] - t0), 64'd6);
    end_test("redir_rsp");

    // Unaligned redirect target, then address wrap at the top of the space.
    lat = 1;
    do_reset();
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h103;
    tick(1);
    bus.redirect = 1'b0;
    tick(5);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(1);
    bus.redirect = 1'b0;
    tick(4);
    check("wrap_req_count", 64'(req_log.size()), 64'd8);
    if (req_log.size() >= 8) begin
      check("align_addr0", req_log[0].addr, 64'h100);
      check("align_addr3", req_log[3].addr, 64'h10C);
      check("wrap_addr_top", req_log[4].addr, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_addr_zero", req_log[5].addr, 64'h0);
      check("wrap_addr_four", req_log[6].addr, 64'h4);
    end
    push_exp(64'hFFFF_FFFF_FFFF_FFFC);
    push_exp(64'h0);
    push_exp(64'h4);
    push_exp(64'h8);
    bus.out_ready = 1'b1;
    wait_hs(4, 40, "wrap");
    end_test("wrap");

    // Reset while full with requests in flight.
    lat = 3;
    do_reset();
    tick(4);
    reset = 1'b1;
    #1;
    check("midrst_req_now", 64'(bus.imem_req), 64'd0);
    tick(1);
    check("midrst_imem_req", 64'(bus.imem_req), 64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_instr", {32'h0, bus.out_instr}, 64'd0);
    check("midrst_out_pc", bus.out_pc, 64'd0);
    check("midrst_out_pc_plus4", bus.out_pc_plus4, 64'd0);
    req_log.delete();
    hs_cyc.delete();
    hs_count = 0;
    reset = 1'b0;
    t0 = cyc;
    #1;
    check("postrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("postrst_imem_req", 64'(bus.imem_req), 64'd1);
    check("postrst_imem_addr", bus.imem_addr, 64'h0);
    bus.out_ready = 1'b1;
    push_exp(64'h0);
    push_exp(64'h4);
    wait_hs(2, 40, "postrst");
    if (req_log.size() >= 1) check("postrst_first_addr", req_log[0].addr, 64'h0);
    end_test("postrst");

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
